cdb_arbiter: RTL and testbench

- Merges the ALU and load-buffer result streams onto one shared common data bus (CDB) broadcast channel.
- The RS, ROB and load buffer snoop that single channel (tag, result).
- Each producer gets a private skid FIFO with backpressure.
- Grants alternate round-robin between the two FIFOs; a ROB flush empties everything.

---
 rtl/cdb_arbiter.sv | 136 +++++++++++++
 tb/tb_cdb_arbiter.sv | 348 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cdb_arbiter.sv
// Merges the ALU and load-buffer result streams onto one registered CDB broadcast.
// Optional CDB_LOAD_PRIORITY_EN: load FIFO gets fixed priority instead of round-robin.
module cdb_arbiter #(
  parameter int ROB_WIDTH  = 4,
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 4
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  input  logic                  rdy_in,
  input  logic                  rob_cdb_rst_in,
  input  logic [ROB_WIDTH-1:0]  alu_cdb_b_in,
  input  logic [DATA_WIDTH-1:0] alu_cdb_result_in,
  output logic                  cdb_alu_rdy_out,
  input  logic [ROB_WIDTH-1:0]  lbuffer_cdb_b_in,
  input  logic [DATA_WIDTH-1:0] lbuffer_cdb_result_in,
  output logic                  cdb_lbuffer_rdy_out,
  output logic [ROB_WIDTH-1:0]  cdb_b_out,
  output logic [DATA_WIDTH-1:0] cdb_result_out
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(DEPTH);

  typedef enum logic {GRANT_ALU = 1'b0, GRANT_LB = 1'b1} grant_e;

  logic [ROB_WIDTH-1:0]  alu_tag_mem  [DEPTH];
  logic [DATA_WIDTH-1:0] alu_data_mem [DEPTH];
  logic [ROB_WIDTH-1:0]  lb_tag_mem   [DEPTH];
  logic [DATA_WIDTH-1:0] lb_data_mem  [DEPTH];

  logic [PW-1:0] alu_head, alu_tail, lb_head, lb_tail;
  logic [CW-1:0] alu_count, lb_count;
  grant_e        last_grant, last_grant_next;

  logic alu_push, lb_push, alu_pop, lb_pop;
  logic alu_nonempty, lb_nonempty, contested;
  logic clear;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  function automatic logic [CW-1:0] count_next(input logic [CW-1:0] c,
                                               input logic push, input logic pop);
    case ({push, pop})
      2'b10:   return c + 1'b1;
      2'b01:   return c - 1'b1;
      default: return c;
    endcase
  endfunction

  // Handshake: a producer presents a nonzero tag as "valid"; it is taken at an
  // edge (rdy_in high, no flush) where its rdy_out was high during that cycle.
  // rdy_out depends only on the registered count, so it never sees a same-cycle pop.
  always_comb begin
    cdb_alu_rdy_out     = alu_count < CW'(DEPTH);
    cdb_lbuffer_rdy_out = lb_count < CW'(DEPTH);
    alu_push            = (alu_cdb_b_in != '0) && cdb_alu_rdy_out;
    lb_push             = (lbuffer_cdb_b_in != '0) && cdb_lbuffer_rdy_out;
    alu_nonempty        = alu_count != '0;
    lb_nonempty         = lb_count != '0;
    contested           = alu_nonempty && lb_nonempty;
    clear               = rst_in || (rdy_in && rob_cdb_rst_in);
  end

  always_comb begin
    last_grant_next = last_grant;
`ifdef CDB_LOAD_PRIORITY_EN
    lb_pop  = lb_nonempty;
    alu_pop = alu_nonempty && !lb_nonempty;
`else
    // Contested grants go to whichever FIFO was not served by the last contest.
    alu_pop = alu_nonempty && (!lb_nonempty || (last_grant == GRANT_LB));
    lb_pop  = lb_nonempty && !alu_pop;
    if (contested) last_grant_next = alu_pop ? GRANT_ALU : GRANT_LB;
`endif
  end

  always_ff @(posedge clk_in) begin
    if (clear) begin
      alu_head       <= '0;
      alu_tail       <= '0;
      alu_count      <= '0;
      lb_head        <= '0;
      lb_tail        <= '0;
      lb_count       <= '0;
      last_grant     <= GRANT_LB;
      cdb_b_out      <= '0;
      cdb_result_out <= '0;
    end else if (rdy_in) begin
      if (alu_push) alu_tail <= ptr_inc(alu_tail);
      if (alu_pop)  alu_head <= ptr_inc(alu_head);
      if (lb_push)  lb_tail  <= ptr_inc(lb_tail);
      if (lb_pop)   lb_head  <= ptr_inc(lb_head);
      alu_count  <= count_next(alu_count, alu_push, alu_pop);
      lb_count   <= count_next(lb_count, lb_push, lb_pop);
      last_grant <= last_grant_next;
      if (alu_pop) begin
        cdb_b_out      <= alu_tag_mem[alu_head];
        cdb_result_out <= alu_data_mem[alu_head];
      end else if (lb_pop) begin
        cdb_b_out      <= lb_tag_mem[lb_head];
        cdb_result_out <= lb_data_mem[lb_head];
      end else begin
        cdb_b_out <= '0;
      end
    end
  end

  // Storage carries no reset; validity is tracked entirely by head/tail/count.
  always_ff @(posedge clk_in) begin
    if (!clear && rdy_in) begin
      if (alu_push) begin
        alu_tag_mem[alu_tail]  <= alu_cdb_b_in;
        alu_data_mem[alu_tail] <= alu_cdb_result_in;
      end
      if (lb_push) begin
        lb_tag_mem[lb_tail]  <= lbuffer_cdb_b_in;
        lb_data_mem[lb_tail] <= lbuffer_cdb_result_in;
      end
    end
  end

`ifndef SYNTHESIS
  always @(posedge clk_in) begin
    if (!clear && rdy_in) begin
      if ((alu_cdb_b_in != '0) && !cdb_alu_rdy_out)
        $display("cdb_arbiter warning: ALU tag %0d dropped, FIFO full", alu_cdb_b_in);
      if ((lbuffer_cdb_b_in != '0) && !cdb_lbuffer_rdy_out)
        $display("cdb_arbiter warning: load tag %0d dropped, FIFO full", lbuffer_cdb_b_in);
    end
  end
`endif

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed self-checking bench for cdb_arbiter; honours CDB_LOAD_PRIORITY_EN when defined.
module tb_cdb_arbiter;

  localparam int ROB_WIDTH  = 4;
  localparam int DATA_WIDTH = 32;
  localparam int DEPTH      = 4;

  logic                  clk_in = 1'b0;
  logic                  rst_in, rdy_in, rob_cdb_rst_in;
  logic [ROB_WIDTH-1:0]  alu_cdb_b_in, lbuffer_cdb_b_in;
  logic [DATA_WIDTH-1:0] alu_cdb_result_in, lbuffer_cdb_result_in;
  logic                  cdb_alu_rdy_out, cdb_lbuffer_rdy_out;
  logic [ROB_WIDTH-1:0]  cdb_b_out;
  logic [DATA_WIDTH-1:0] cdb_result_out;

  int pass_cnt  = 0;
  int total_cnt = 0;

  logic [ROB_WIDTH-1:0]  exp_q[$];
  logic [ROB_WIDTH-1:0]  obs_tag_q[$];
  logic [DATA_WIDTH-1:0] obs_data_q[$];
  bit alu_low_seen;

  cdb_arbiter #(.ROB_WIDTH(ROB_WIDTH), .DATA_WIDTH(DATA_WIDTH), .DEPTH(DEPTH)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .rob_cdb_rst_in(rob_cdb_rst_in),
    .alu_cdb_b_in(alu_cdb_b_in), .alu_cdb_result_in(alu_cdb_result_in),
    .cdb_alu_rdy_out(cdb_alu_rdy_out),
    .lbuffer_cdb_b_in(lbuffer_cdb_b_in), .lbuffer_cdb_result_in(lbuffer_cdb_result_in),
    .cdb_lbuffer_rdy_out(cdb_lbuffer_rdy_out),
    .cdb_b_out(cdb_b_out), .cdb_result_out(cdb_result_out)
  );

  // ---------------- clock / reset ----------------
  always #5 clk_in = ~clk_in;

  function automatic logic [DATA_WIDTH-1:0] alu_val(input int t);
    return 32'hA000_0000 + DATA_WIDTH'(t);
  endfunction

  function automatic logic [DATA_WIDTH-1:0] lb_val(input int t);
    return 32'hB000_0000 + DATA_WIDTH'(t);
  endfunction

  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  task automatic idle_inputs();
    alu_cdb_b_in          = '0;
    alu_cdb_result_in     = '0;
    lbuffer_cdb_b_in      = '0;
    lbuffer_cdb_result_in = '0;
    rob_cdb_rst_in        = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rdy_in = 1'b1;
    rst_in = 1'b1;
    step();
    step();
    rst_in = 1'b0;
  endtask

  // ---------------- driver ----------------
  task automatic drive_alu(input int t);
    alu_cdb_b_in      = ROB_WIDTH'(t);
    alu_cdb_result_in = alu_val(t);
  endtask

  task automatic drive_lb(input int t);
    lbuffer_cdb_b_in      = ROB_WIDTH'(t);
    lbuffer_cdb_result_in = lb_val(t);
  endtask

  // Streams ALU tags 1..n_alu and LB tags lb_base.. respecting ready; logs broadcasts.
  task automatic run_stream(input int n_alu, input int n_lb, input int lb_base, input int budget);
    int ai = 0;
    int li = 0;
    int cyc = 0;
    bit alu_acc, lb_acc;
    obs_tag_q.delete();
    obs_data_q.delete();
    alu_low_seen = 1'b0;
    while ((obs_tag_q.size() < n_alu + n_lb) && (cyc < budget)) begin
      if (ai < n_alu) drive_alu(ai + 1); else begin alu_cdb_b_in = '0; alu_cdb_result_in = '0; end
      if (li < n_lb) drive_lb(lb_base + li); else begin lbuffer_cdb_b_in = '0; lbuffer_cdb_result_in = '0; end
      if (!cdb_alu_rdy_out) alu_low_seen = 1'b1;
      alu_acc = (ai < n_alu) && cdb_alu_rdy_out;
      lb_acc  = (li < n_lb) && cdb_lbuffer_rdy_out;
      step();
      cyc++;
      if (alu_acc) ai++;
      if (lb_acc) li++;
      if (cdb_b_out != '0) begin
        obs_tag_q.push_back(cdb_b_out);
        obs_data_q.push_back(cdb_result_out);
      end
    end
    idle_inputs();
    total_cnt++;
    if (obs_tag_q.size() != n_alu + n_lb)
      $display("FAIL stream_count: got %0d broadcasts, expected %0d within %0d cycles",
               obs_tag_q.size(), n_alu + n_lb, budget);
    else pass_cnt++;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    idle_inputs();
    rdy_in = 1'b1;
    rst_in = 1'b1;
    drive_alu(7);
    step();
    total_cnt++;
    if (cdb_b_out !== '0) $display("FAIL reset_tag: got %0d expected 0", cdb_b_out); else pass_cnt++;
    total_cnt++;
    if (cdb_result_out !== '0) $display("FAIL reset_data: got %h expected 0", cdb_result_out); else pass_cnt++;
    total_cnt++;
    if (cdb_alu_rdy_out !== 1'b1 || cdb_lbuffer_rdy_out !== 1'b1)
      $display("FAIL reset_ready: got alu=%b lb=%b expected 1/1", cdb_alu_rdy_out, cdb_lbuffer_rdy_out);
    else pass_cnt++;
    step();
    rst_in = 1'b0;
    idle_inputs();
    step();
    step();
    total_cnt++;
    if (cdb_b_out !== '0) $display("FAIL reset_no_capture: got %0d expected 0", cdb_b_out); else pass_cnt++;
  endtask

  task automatic test_single();
    do_reset();
    alu_cdb_b_in      = 4'd3;
    alu_cdb_result_in = 32'h11;
    step();
    idle_inputs();
    total_cnt++;
    if (cdb_b_out !== '0) $display("FAIL single_latency1: got %0d expected 0", cdb_b_out); else pass_cnt++;
    step();
    total_cnt++;
    if (cdb_b_out !== 4'd3) $display("FAIL single_tag: got %0d expected 3", cdb_b_out); else pass_cnt++;
    total_cnt++;
    if (cdb_result_out !== 32'h11) $display("FAIL single_data: got %h expected 11", cdb_result_out); else pass_cnt++;
    step();
    total_cnt++;
    if (cdb_b_out !== '0) $display("FAIL single_idle: got %0d expected 0", cdb_b_out); else pass_cnt++;
    total_cnt++;
    if (cdb_result_out !== 32'h11) $display("FAIL single_hold: got %h expected 11", cdb_result_out); else pass_cnt++;
  endtask

  task automatic test_interleave();
    logic [ROB_WIDTH-1:0] e;
    int k = 0;
    do_reset();
    exp_q.delete();
`ifdef CDB_LOAD_PRIORITY_EN
    exp_q = '{4'd5, 4'd6, 4'd7, 4'd8, 4'd1, 4'd2, 4'd3, 4'd4};
`else
    exp_q = '{4'd1, 4'd5, 4'd2, 4'd6, 4'd3, 4'd7, 4'd4, 4'd8};
`endif
    run_stream(4, 4, 5, 40);
    while (exp_q.size() > 0 && k < obs_tag_q.size()) begin
      e = exp_q.pop_front();
      total_cnt++;
      if (obs_tag_q[k] !== e) $display("FAIL order_%0d: got %0d expected %0d", k, obs_tag_q[k], e);
      else pass_cnt++;
      total_cnt++;
      if (obs_data_q[k] !== ((e < 4'd5) ? alu_val(int'(e)) : lb_val(int'(e))))
        $display("FAIL order_data_%0d: got %h for tag %0d", k, obs_data_q[k], e);
      else pass_cnt++;
      k++;
    end
  endtask

  task automatic test_backpressure();
    int na = 0;
    int nl = 0;
    do_reset();
    run_stream(10, 4, 11, 80);
    total_cnt++;
    if (!alu_low_seen) $display("FAIL bp_ready_drop: got ready never low, expected low"); else pass_cnt++;
    for (int k = 0; k < obs_tag_q.size(); k++) begin
      if (obs_tag_q[k] < 4'd11) begin
        na++;
        total_cnt++;
        if (obs_tag_q[k] !== ROB_WIDTH'(na) || obs_data_q[k] !== alu_val(na))
          $display("FAIL bp_alu_%0d: got %0d/%h expected %0d/%h", na, obs_tag_q[k], obs_data_q[k], na, alu_val(na));
        else pass_cnt++;
      end else begin
        total_cnt++;
        if (obs_tag_q[k] !== ROB_WIDTH'(11 + nl) || obs_data_q[k] !== lb_val(11 + nl))
          $display("FAIL bp_lb_%0d: got %0d/%h expected %0d/%h", nl, obs_tag_q[k], obs_data_q[k], 11 + nl, lb_val(11 + nl));
        else pass_cnt++;
        nl++;
      end
    end
  endtask

  task automatic test_wrap();
    int na = 0;
    int nl = 0;
    do_reset();
    run_stream(7, 7, 8, 80);
    for (int k = 0; k < obs_tag_q.size(); k++) begin
      if (obs_tag_q[k] < 4'd8) begin
        na++;
        total_cnt++;
        if (obs_tag_q[k] !== ROB_WIDTH'(na) || obs_data_q[k] !== alu_val(na))
          $display("FAIL wrap_alu_%0d: got %0d/%h expected %0d/%h", na, obs_tag_q[k], obs_data_q[k], na, alu_val(na));
        else pass_cnt++;
      end else begin
        total_cnt++;
        if (obs_tag_q[k] !== ROB_WIDTH'(8 + nl) || obs_data_q[k] !== lb_val(8 + nl))
          $display("FAIL wrap_lb_%0d: got %0d/%h expected %0d/%h", nl, obs_tag_q[k], obs_data_q[k], 8 + nl, lb_val(8 + nl));
        else pass_cnt++;
        nl++;
      end
    end
  endtask

  task automatic test_flush();
    logic [ROB_WIDTH-1:0] pre_exp, first_exp, second_exp;
`ifdef CDB_LOAD_PRIORITY_EN
    pre_exp = 4'd7; first_exp = 4'd12; second_exp = 4'd11;
`else
    pre_exp = 4'd2; first_exp = 4'd11; second_exp = 4'd12;
`endif
    do_reset();
    for (int i = 0; i < 4; i++) begin
      drive_alu(i + 1);
      drive_lb(i + 5);
      step();
    end
    total_cnt++;
    if (cdb_b_out !== pre_exp) $display("FAIL flush_pre: got %0d expected %0d", cdb_b_out, pre_exp); else pass_cnt++;
    idle_inputs();
    drive_alu(9);
    rob_cdb_rst_in = 1'b1;
    step();
    idle_inputs();
    total_cnt++;
    if (cdb_b_out !== '0 || cdb_result_out !== '0)
      $display("FAIL flush_out: got %0d/%h expected 0/0", cdb_b_out, cdb_result_out);
    else pass_cnt++;
    total_cnt++;
    if (cdb_alu_rdy_out !== 1'b1 || cdb_lbuffer_rdy_out !== 1'b1)
      $display("FAIL flush_ready: got alu=%b lb=%b expected 1/1", cdb_alu_rdy_out, cdb_lbuffer_rdy_out);
    else pass_cnt++;
    drive_alu(11);
    drive_lb(12);
    step();
    idle_inputs();
    total_cnt++;
    if (cdb_b_out !== '0) $display("FAIL flush_empty: got %0d expected 0", cdb_b_out); else pass_cnt++;
    step();
    total_cnt++;
    if (cdb_b_out !== first_exp) $display("FAIL flush_grant1: got %0d expected %0d", cdb_b_out, first_exp); else pass_cnt++;
    step();
    total_cnt++;
    if (cdb_b_out !== second_exp) $display("FAIL flush_grant2: got %0d expected %0d", cdb_b_out, second_exp); else pass_cnt++;
    for (int i = 0; i < 3; i++) begin
      step();
      total_cnt++;
      if (cdb_b_out !== '0) $display("FAIL flush_idle_%0d: got %0d expected 0", i, cdb_b_out); else pass_cnt++;
    end
  endtask

  task automatic test_hold();
    logic [ROB_WIDTH-1:0] first_exp, second_exp;
`ifdef CDB_LOAD_PRIORITY_EN
    first_exp = 4'd5; second_exp = 4'd4;
`else
    first_exp = 4'd4; second_exp = 4'd5;
`endif
    do_reset();
    drive_alu(3);
    step();
    drive_alu(4);
    drive_lb(5);
    step();
    idle_inputs();
    total_cnt++;
    if (cdb_b_out !== 4'd3) $display("FAIL hold_pre: got %0d expected 3", cdb_b_out); else pass_cnt++;
    rdy_in = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      total_cnt++;
      if (cdb_b_out !== 4'd3 || cdb_result_out !== alu_val(3))
        $display("FAIL hold_frozen_%0d: got %0d/%h expected 3/%h", i, cdb_b_out, cdb_result_out, alu_val(3));
      else pass_cnt++;
    end
    rdy_in = 1'b1;
    step();
    total_cnt++;
    if (cdb_b_out !== first_exp) $display("FAIL hold_out1: got %0d expected %0d", cdb_b_out, first_exp); else pass_cnt++;
    step();
    total_cnt++;
    if (cdb_b_out !== second_exp) $display("FAIL hold_out2: got %0d expected %0d", cdb_b_out, second_exp); else pass_cnt++;
    step();
    total_cnt++;
    if (cdb_b_out !== '0) $display("FAIL hold_drained: got %0d expected 0", cdb_b_out); else pass_cnt++;
  endtask

  task automatic test_reset_midstream();
    do_reset();
    drive_alu(1);
    drive_lb(2);
    step();
    drive_alu(3);
    drive_lb(0);
    step();
    idle_inputs();
    total_cnt++;
    if (cdb_b_out !== 4'd1) $display("FAIL mid_pre: got %0d expected 1", cdb_b_out); else pass_cnt++;
    rst_in = 1'b1;
    step();
    rst_in = 1'b0;
    total_cnt++;
    if (cdb_b_out !== '0 || cdb_result_out !== '0)
      $display("FAIL mid_reset_out: got %0d/%h expected 0/0", cdb_b_out, cdb_result_out);
    else pass_cnt++;
    for (int i = 0; i < 4; i++) begin
      step();
      total_cnt++;
      if (cdb_b_out !== '0) $display("FAIL mid_lost_%0d: got %0d expected 0", i, cdb_b_out); else pass_cnt++;
    end
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    idle_inputs();
    rdy_in = 1'b1;
    rst_in = 1'b1;
    test_reset();
    test_single();
    test_interleave();
    test_backpressure();
    test_wrap();
    test_flush();
    test_hold();
    test_reset_midstream();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
